// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection (HAZARD_DETECT_EN), flush and a saturating stall counter.
// Latency: one cycle from id_* to ex_*; stall is combinational from the current ex_* and id_* values.
// Backpressure: stall asks upstream to hold PC and IF/ID while a bubble goes to EX; flush overrides stall.
module id_ex_stage #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              id_RegDst,
    input  logic              id_Branch,
    input  logic              id_MemtoReg,
    input  logic              id_ALUSrc,
    input  logic              id_RegWrite,
    input  logic [1:0]        id_Jump,
    input  logic [1:0]        id_ALUOp,
    input  logic [1:0]        id_MemRead,
    input  logic [1:0]        id_MemWrite,
    input  logic [DATA_W-1:0] id_rd1,
    input  logic [DATA_W-1:0] id_rd2,
    input  logic [DATA_W-1:0] id_imm,
    input  logic [DATA_W-1:0] id_pc4,
    input  logic [4:0]        id_rs,
    input  logic [4:0]        id_rt,
    input  logic [4:0]        id_rd,
    output logic              ex_RegDst,
    output logic              ex_Branch,
    output logic              ex_MemtoReg,
    output logic              ex_ALUSrc,
    output logic              ex_RegWrite,
    output logic [1:0]        ex_Jump,
    output logic [1:0]        ex_ALUOp,
    output logic [1:0]        ex_MemRead,
    output logic [1:0]        ex_MemWrite,
    output logic [DATA_W-1:0] ex_rd1,
    output logic [DATA_W-1:0] ex_rd2,
    output logic [DATA_W-1:0] ex_imm,
    output logic [DATA_W-1:0] ex_pc4,
    output logic [4:0]        ex_rs,
    output logic [4:0]        ex_rt,
    output logic [4:0]        ex_rd,
    output logic              ex_valid,
    output logic              stall,
    output logic [CNT_W-1:0]  stall_cnt
);

    logic bubble;

`ifdef HAZARD_DETECT_EN
    // A load in EX whose destination feeds the ID instruction cannot forward in time.
    assign stall = ex_valid & (ex_MemRead != 2'b00) & (ex_rt != 5'd0)
                 & ((ex_rt == id_rs) | (ex_rt == id_rt)) & ~flush;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt <= '0;
        end else if (stall && (stall_cnt != {CNT_W{1'b1}})) begin
            stall_cnt <= stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end
`else
    assign stall     = 1'b0;
    assign stall_cnt = '0;
`endif

    assign bubble = flush | stall;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ex_RegDst   <= 1'b0;
            ex_Branch   <= 1'b0;
            ex_MemtoReg <= 1'b0;
            ex_ALUSrc   <= 1'b0;
            ex_RegWrite <= 1'b0;
            ex_Jump     <= 2'b00;
            ex_ALUOp    <= 2'b00;
            ex_MemRead  <= 2'b00;
            ex_MemWrite <= 2'b00;
            ex_rd1      <= '0;
            ex_rd2      <= '0;
            ex_imm      <= '0;
            ex_pc4      <= '0;
            ex_rs       <= 5'd0;
            ex_rt       <= 5'd0;
            ex_rd       <= 5'd0;
            ex_valid    <= 1'b0;
        end else if (bubble) begin
            // Bubbles zero data too so nothing downstream ever sees X from a killed slot.
            ex_RegDst   <= 1'b0;
            ex_Branch   <= 1'b0;
            ex_MemtoReg <= 1'b0;
            ex_ALUSrc   <= 1'b0;
            ex_RegWrite <= 1'b0;
            ex_Jump     <= 2'b00;
            ex_ALUOp    <= 2'b00;
            ex_MemRead  <= 2'b00;
            ex_MemWrite <= 2'b00;
            ex_rd1      <= '0;
            ex_rd2      <= '0;
            ex_imm      <= '0;
            ex_pc4      <= '0;
            ex_rs       <= 5'd0;
            ex_rt       <= 5'd0;
            ex_rd       <= 5'd0;
            ex_valid    <= 1'b0;
        end else begin
            ex_RegDst   <= id_RegDst;
            ex_Branch   <= id_Branch;
            ex_MemtoReg <= id_MemtoReg;
            ex_ALUSrc   <= id_ALUSrc;
            ex_RegWrite <= id_RegWrite;
            ex_Jump     <= id_Jump;
            ex_ALUOp    <= id_ALUOp;
            ex_MemRead  <= id_MemRead;
            ex_MemWrite <= id_MemWrite;
            ex_rd1      <= id_rd1;
            ex_rd2      <= id_rd2;
            ex_imm      <= id_imm;
            ex_pc4      <= id_pc4;
            ex_rs       <= id_rs;
            ex_rt       <= id_rt;
            ex_rd       <= id_rd;
            ex_valid    <= 1'b1;
        end
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboarded bench for id_ex_stage: driver pushes model expectations, monitor pops and compares.
`timescale 1ns/1ps
module tb_id_ex_stage;

`ifdef HAZARD_DETECT_EN
    localparam bit HZ = 1'b1;
`else
    localparam bit HZ = 1'b0;
`endif

    typedef struct packed {
        logic        RegDst;
        logic        Branch;
        logic        MemtoReg;
        logic        ALUSrc;
        logic        RegWrite;
        logic [1:0]  Jump;
        logic [1:0]  ALUOp;
        logic [1:0]  MemRead;
        logic [1:0]  MemWrite;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] imm;
        logic [31:0] pc4;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
    } instr_t;

    typedef struct packed {
        instr_t      ex;
        logic        valid;
        logic [15:0] cnt;
        logic [1:0]  scnt;
    } state_t;

    logic   clk = 1'b0;
    logic   reset;
    logic   flush;
    instr_t id;

    wire instr_t      ex_bus;
    wire instr_t      s_bus;
    wire logic        ex_valid, s_valid;
    wire logic        stall, s_stall;
    wire logic [15:0] stall_cnt;
    wire logic [1:0]  s_cnt;

    int checks   = 0;
    int failures = 0;

    // Reference model: the instruction sitting in EX, whether it is real, and bubble counts.
    instr_t m_ex;
    bit     m_valid;
    int     m_cnt;
    int     m_scnt;

    logic   stall_q[$];
    state_t state_q[$];

    always #5 clk = ~clk;

    id_ex_stage #(.DATA_W(32), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .id_RegDst(id.RegDst), .id_Branch(id.Branch), .id_MemtoReg(id.MemtoReg),
        .id_ALUSrc(id.ALUSrc), .id_RegWrite(id.RegWrite), .id_Jump(id.Jump),
        .id_ALUOp(id.ALUOp), .id_MemRead(id.MemRead), .id_MemWrite(id.MemWrite),
        .id_rd1(id.rd1), .id_rd2(id.rd2), .id_imm(id.imm), .id_pc4(id.pc4),
        .id_rs(id.rs), .id_rt(id.rt), .id_rd(id.rd),
        .ex_RegDst(ex_bus.RegDst), .ex_Branch(ex_bus.Branch), .ex_MemtoReg(ex_bus.MemtoReg),
        .ex_ALUSrc(ex_bus.ALUSrc), .ex_RegWrite(ex_bus.RegWrite), .ex_Jump(ex_bus.Jump),
        .ex_ALUOp(ex_bus.ALUOp), .ex_MemRead(ex_bus.MemRead), .ex_MemWrite(ex_bus.MemWrite),
        .ex_rd1(ex_bus.rd1), .ex_rd2(ex_bus.rd2), .ex_imm(ex_bus.imm), .ex_pc4(ex_bus.pc4),
        .ex_rs(ex_bus.rs), .ex_rt(ex_bus.rt), .ex_rd(ex_bus.rd),
        .ex_valid(ex_valid), .stall(stall), .stall_cnt(stall_cnt)
    );

    id_ex_stage #(.DATA_W(32), .CNT_W(2)) dut_small (
        .clk(clk), .reset(reset), .flush(flush),
        .id_RegDst(id.RegDst), .id_Branch(id.Branch), .id_MemtoReg(id.MemtoReg),
        .id_ALUSrc(id.ALUSrc), .id_RegWrite(id.RegWrite), .id_Jump(id.Jump),
        .id_ALUOp(id.ALUOp), .id_MemRead(id.MemRead), .id_MemWrite(id.MemWrite),
        .id_rd1(id.rd1), .id_rd2(id.rd2), .id_imm(id.imm), .id_pc4(id.pc4),
        .id_rs(id.rs), .id_rt(id.rt), .id_rd(id.rd),
        .ex_RegDst(s_bus.RegDst), .ex_Branch(s_bus.Branch), .ex_MemtoReg(s_bus.MemtoReg),
        .ex_ALUSrc(s_bus.ALUSrc), .ex_RegWrite(s_bus.RegWrite), .ex_Jump(s_bus.Jump),
        .ex_ALUOp(s_bus.ALUOp), .ex_MemRead(s_bus.MemRead), .ex_MemWrite(s_bus.MemWrite),
        .ex_rd1(s_bus.rd1), .ex_rd2(s_bus.rd2), .ex_imm(s_bus.imm), .ex_pc4(s_bus.pc4),
        .ex_rs(s_bus.rs), .ex_rt(s_bus.rt), .ex_rd(s_bus.rd),
        .ex_valid(s_valid), .stall(s_stall), .stall_cnt(s_cnt)
    );

    task automatic check(input string nm, input logic [199:0] act, input logic [199:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    function automatic instr_t rnd_instr();
        instr_t r;
        r.RegDst   = 1'($urandom_range(1, 0));
        r.Branch   = 1'($urandom_range(1, 0));
        r.MemtoReg = 1'($urandom_range(1, 0));
        r.ALUSrc   = 1'($urandom_range(1, 0));
        r.RegWrite = 1'($urandom_range(1, 0));
        r.Jump     = 2'($urandom_range(3, 0));
        r.ALUOp    = 2'($urandom_range(3, 0));
        r.MemRead  = 2'($urandom_range(3, 0));
        r.MemWrite = 2'($urandom_range(3, 0));
        r.rd1      = $urandom;
        r.rd2      = $urandom;
        r.imm      = $urandom;
        r.pc4      = $urandom;
        // Small register range so load-use collisions (and $zero) are frequent.
        r.rs       = 5'($urandom_range(3, 0));
        r.rt       = 5'($urandom_range(3, 0));
        r.rd       = 5'($urandom_range(31, 0));
        return r;
    endfunction

    task automatic model_reset();
        m_ex    = '0;
        m_valid = 1'b0;
        m_cnt   = 0;
        m_scnt  = 0;
    endtask

    // Present one instruction for one cycle and record what the DUT must do with it.
    task automatic drive(input instr_t i, input logic f, output logic exp_stall);
        state_t st;
        @(negedge clk);
        id    = i;
        flush = f;
        #1;
        exp_stall = HZ && m_valid && (m_ex.MemRead != 2'b00) && (m_ex.rt != 5'd0)
                    && ((m_ex.rt == i.rs) || (m_ex.rt == i.rt)) && !f;
        stall_q.push_back(exp_stall);
        if (f || exp_stall) begin
            m_ex    = '0;
            m_valid = 1'b0;
        end else begin
            m_ex    = i;
            m_valid = 1'b1;
        end
        if (exp_stall) begin
            if (m_cnt < 65535) m_cnt = m_cnt + 1;
            if (m_scnt < 3) m_scnt = m_scnt + 1;
        end
        st.ex    = m_ex;
        st.valid = m_valid;
        st.cnt   = 16'(m_cnt);
        st.scnt  = 2'(m_scnt);
        state_q.push_back(st);
    endtask

    // Monitor: stall is checked mid-cycle, registered outputs just after each rising edge.
    initial begin
        logic   es;
        state_t est;
        forever begin
            @(negedge clk);
            #2;
            if (stall_q.size() > 0) begin
                es = stall_q.pop_front();
                check("stall", {199'd0, stall}, {199'd0, es});
                check("stall_small", {199'd0, s_stall}, {199'd0, es});
            end
            @(posedge clk);
            #1;
            if (state_q.size() > 0) begin
                est = state_q.pop_front();
                check("ex_bundle", {44'd0, ex_bus}, {44'd0, est.ex});
                check("ex_valid", {199'd0, ex_valid}, {199'd0, est.valid});
                check("stall_cnt", {184'd0, stall_cnt}, {184'd0, est.cnt});
                check("stall_cnt_sat", {198'd0, s_cnt}, {198'd0, est.scnt});
                check("ex_bundle_small", {44'd0, s_bus}, {44'd0, est.ex});
            end
        end
    end

    initial begin
        instr_t rt_i, lw_i, use_i, lw0_i, use0_i, cur;
        logic   s;
        bit     hold;

        reset = 1'b1;
        flush = 1'b0;
        id    = '0;
        model_reset();
        #2;
        check("reset_bundle", {44'd0, ex_bus}, 200'd0);
        check("reset_valid", {199'd0, ex_valid}, 200'd0);
        check("reset_stall", {199'd0, stall}, 200'd0);
        check("reset_cnt", {184'd0, stall_cnt}, 200'd0);
        @(negedge clk);
        reset = 1'b0;

        // R-type pass-through
        rt_i = '0;
        rt_i.RegWrite = 1'b1;
        rt_i.RegDst   = 1'b1;
        rt_i.ALUOp    = 2'b10;
        rt_i.rd1      = 32'h0000_0005;
        rt_i.rd2      = 32'h0000_0007;
        rt_i.pc4      = 32'h0040_0004;
        rt_i.rs       = 5'd1;
        rt_i.rt       = 5'd2;
        rt_i.rd       = 5'd8;
        drive(rt_i, 1'b0, s);

        // lw $9 followed by a consumer of $9, re-presented after the stall
        lw_i = '0;
        lw_i.MemRead  = 2'b01;
        lw_i.MemtoReg = 1'b1;
        lw_i.ALUSrc   = 1'b1;
        lw_i.RegWrite = 1'b1;
        lw_i.rs       = 5'd3;
        lw_i.rt       = 5'd9;
        lw_i.imm      = 32'h0000_0010;
        lw_i.pc4      = 32'h0040_0008;
        use_i = rt_i;
        use_i.rs  = 5'd9;
        use_i.rt  = 5'd4;
        use_i.pc4 = 32'h0040_000c;
        drive(lw_i, 1'b0, s);
        drive(use_i, 1'b0, s);
        drive(use_i, 1'b0, s);

        // A load into $zero never stalls
        lw0_i = lw_i;
        lw0_i.rt = 5'd0;
        use0_i = use_i;
        use0_i.rs = 5'd0;
        drive(lw0_i, 1'b0, s);
        drive(use0_i, 1'b0, s);

        // Flush wins over a hazard: bubble without counting
        drive(lw_i, 1'b0, s);
        drive(use_i, 1'b1, s);

        // Back-to-back loads into the same register
        drive(lw_i, 1'b0, s);
        cur = lw_i;
        cur.rs = 5'd9;
        drive(cur, 1'b0, s);
        drive(cur, 1'b0, s);
        drive(use_i, 1'b0, s);
        drive(use_i, 1'b0, s);

        // Five load-use stalls push the 2-bit counter into saturation
        for (int k = 0; k < 5; k++) begin
            drive(lw_i, 1'b0, s);
            drive(use_i, 1'b0, s);
            drive(use_i, 1'b0, s);
        end

        // Random traffic; a stalled instruction is held and re-presented
        hold = 1'b0;
        cur  = rnd_instr();
        for (int n = 0; n < 600; n++) begin
            if (!hold) cur = rnd_instr();
            drive(cur, ($urandom_range(9, 0) == 0), s);
            hold = s;
        end

        // Reset asserted mid-cycle with a RegWrite instruction in EX
        drive(lw_i, 1'b1, s);
        drive(rt_i, 1'b0, s);
        drive(use_i, 1'b0, s);
        @(negedge clk);
        #3;
        check("pre_reset_regwrite", {199'd0, ex_bus.RegWrite}, {199'd0, m_ex.RegWrite});
        reset = 1'b1;
        #1;
        model_reset();
        check("async_reset_bundle", {44'd0, ex_bus}, 200'd0);
        check("async_reset_valid", {199'd0, ex_valid}, 200'd0);
        check("async_reset_stall", {199'd0, stall}, 200'd0);
        check("async_reset_cnt", {184'd0, stall_cnt}, 200'd0);
        check("async_reset_cnt_small", {198'd0, s_cnt}, 200'd0);
        @(negedge clk);
        reset = 1'b0;

        drive(lw_i, 1'b0, s);
        drive(use_i, 1'b0, s);
        drive(use_i, 1'b0, s);
        drive(rt_i, 1'b0, s);

        repeat (3) @(posedge clk);
        #2;
        check("scoreboard_drained", 200'(stall_q.size() + state_q.size()), 200'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline register of the pipelined MIPS datapath, directly downstream of the main control decoder and register file. It captures the decoded control bundle, operands, immediate, register specifiers and PC+4 for the EX stage. It detects load-use hazards, inserts bubbles and accepts a branch/jump flush. It also keeps a saturating stall counter for performance analysis.

## Interface
- DATA_W, 32, width of register operands, immediate and PC+4
- CNT_W, 16, width of the stall counter
- clk  in  1  pipeline clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high reset
- flush  in  1  kill the instruction entering EX (taken branch/jump)
- id_RegDst, id_Branch, id_MemtoReg, id_ALUSrc, id_RegWrite  in  1 each  decoded control bits
- id_Jump, id_ALUOp, id_MemRead, id_MemWrite  in  2 each  decoded control fields; MemRead/MemWrite: 00 none, 01 word, 10 byte, 11 half
- id_rd1, id_rd2  in  DATA_W  register file read data
- id_imm  in  DATA_W  sign-extended immediate
- id_pc4  in  DATA_W  PC+4 of the ID instruction
- id_rs, id_rt, id_rd  in  5 each  register specifiers
- ex_* (same names and widths as every id_* input above)  out  registered copies for EX
- ex_valid  out  1  EX holds a real instruction (not a bubble)
- stall  out  1  hold PC and IF/ID this cycle
- stall_cnt  out  CNT_W  number of bubble cycles inserted since reset

## Operation
- Load-use hazard (combinational): stall = ex_valid & (ex_MemRead != 00) & (ex_rt != 0) & ((ex_rt == id_rs) | (ex_rt == id_rt)) & ~flush.
- Each rising edge, priority high to low:
  - flush = 1: load a bubble.
  - stall = 1: load a bubble.
  - Otherwise: load all id_* into ex_*; ex_valid <= 1.
- Bubble: every control output (RegDst, Jump, Branch, MemRead, MemtoReg, ALUOp, MemWrite, ALUSrc, RegWrite) and ex_valid cleared to 0. Data and specifier outputs also cleared to 0, never left X.
- X sanitising: control inputs driven X by the decoder (don't-care on stores and jumps) are captured as-is on normal loads. Downstream only qualifies them by ex_valid, RegWrite, MemRead and MemWrite, which are never X.
- stall_cnt increments by 1 on each edge where stall = 1 and the bubble is loaded. It saturates at all-ones and never wraps. Flush-only bubbles are not counted.
- The register is single-entry with no internal state machine beyond ex_valid and the counter.

## Timing
- Reset: all ex_* = 0, ex_valid = 0, stall_cnt = 0. Consequently stall = 0.
- Reset asserted mid-stall clears state immediately, asynchronously. stall drops in the same cycle because ex_valid = 0.
- Latency: id_* sampled at edge N appears on ex_* after edge N; one cycle.
- stall is valid within the cycle, from current ex_* and id_* values. Upstream must hold id_* stable during a stall so the same instruction is re-presented next cycle.
- A stall lasts exactly one cycle per load. The bubble clears ex_valid, so stall deasserts the following cycle.
- flush and a hazard in the same cycle: flush wins, stall = 0, no count increment.
- Back-to-back loads into the same register: each dependent consumer stalls one cycle independently.

## Configuration
- HAZARD_DETECT_EN defined: load-use detection, stall generation and stall_cnt are active as described.
- HAZARD_DETECT_EN undefined:
  - stall is tied to 0 and stall_cnt is tied to 0.
  - The register loads every cycle unless flushed.
  - Software is responsible for load delay slots.

## Test plan
- Reset: assert reset mid-run with ex_RegWrite = 1 -> all outputs 0 immediately, stall = 0, stall_cnt = 0.
- Pass-through: R-type (id_RegWrite = 1, id_RegDst = 1, id_rd1 = 32'h0000_0005, id_rd = 8) -> next edge ex_* match, ex_valid = 1, stall = 0.
- Load-use: lw ex_rt = 9 in EX, then id_rs = 9 -> stall = 1. The next edge loads a bubble (ex_RegWrite = 0, ex_valid = 0) and stall_cnt = 1. Re-presented instruction loads on the following edge.
- No hazard on $zero: lw with ex_rt = 0, id_rs = 0 -> stall = 0.
- Flush + hazard: same hazard as the load-use scenario with flush = 1 -> stall = 0, bubble loaded, stall_cnt unchanged.
- Counter saturation: CNT_W = 2, force 5 load-use stalls -> stall_cnt = 3 and holds.
